mt_thread_sched: RTL

MT_THREAD_SCHED -- requirements
Module: mt_thread_sched

---
 rtl/mt_pkg.sv | 18 +
 rtl/mt_rr_pick.sv | 41 ++++
 rtl/mt_thread_sched.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mt_pkg.sv
// mt_pkg: shared definitions for the multithreaded front end.
// Used by mt_thread_sched, mt_rr_pick and mt_pc.
package mt_pkg;

  // Default machine configuration.
  localparam int MT_NUM_THREADS  = 8;
  localparam int MT_BITS_THREADS = $clog2(MT_NUM_THREADS);
  localparam int MT_SLEEP_W      = 4;

  // Thread identifier as carried between the scheduler and the PC stage.
  typedef logic [MT_BITS_THREADS-1:0] tid_t;

  // Even parity over a thread id, for stages that protect tid in flight.
  function automatic logic tid_parity(input tid_t t);
    return ^t;
  endfunction

endpackage

// File: rtl/mt_rr_pick.sv
// mt_rr_pick: rotating find-first.
// Returns the first set bit of 'eligible' strictly after 'ptr', searching
// upward and wrapping from NUM_THREADS-1 to 0.  The pointer position itself
// is examined last, so a lone eligible thread is always found.
module mt_rr_pick
  import mt_pkg::*;
#(
  parameter int NUM_THREADS  = MT_NUM_THREADS,
  parameter int BITS_THREADS = $clog2(NUM_THREADS)
) (
  input  logic [NUM_THREADS-1:0]  eligible,
  input  logic [BITS_THREADS-1:0] ptr,
  output logic [BITS_THREADS-1:0] winner,
  output logic                    found
);

  logic [BITS_THREADS-1:0] winner_s;
  logic                    found_s;

  // Walk the threads in rotating order and latch the first eligible one.
  always_comb begin
    winner_s = ptr;
    found_s  = 1'b0;
    for (int i = 1; i <= NUM_THREADS; i++) begin
      logic [BITS_THREADS-1:0] idx_s;
      // NUM_THREADS is a power of two, so the id width wraps naturally.
      idx_s = ptr + BITS_THREADS'(i);
      if (!found_s && eligible[idx_s]) begin
        found_s  = 1'b1;
        winner_s = idx_s;
      end else begin
        found_s  = found_s;
        winner_s = winner_s;
      end
    end
  end

  assign winner = winner_s;
  assign found  = found_s;

endmodule

// File: rtl/mt_thread_sched.sv
// mt_thread_sched: round-robin hardware-thread issue scheduler for mt_pc.
// Issues one eligible thread per cycle (registered tid/tid_valid), tracks
// which threads are active, and optionally blocks threads for a number of
// cycles.  Build option: define MT_SCHED_SLEEP_EN to compile in the
// per-thread sleep counters; without it the sleep_* inputs are ignored.
module mt_thread_sched
  import mt_pkg::*;
#(
  parameter int NUM_THREADS  = MT_NUM_THREADS,
  parameter int BITS_THREADS = $clog2(NUM_THREADS),
  parameter int SLEEP_W      = MT_SLEEP_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_valid,
  input  logic [BITS_THREADS-1:0] start_tid,
  input  logic                    halt_valid,
  input  logic [BITS_THREADS-1:0] halt_tid,
  input  logic                    sleep_valid,
  input  logic [BITS_THREADS-1:0] sleep_tid,
  input  logic [SLEEP_W-1:0]      sleep_cycles,
  input  logic                    fetch_stall,
  output logic [BITS_THREADS-1:0] tid,
  output logic                    tid_valid,
  output logic [NUM_THREADS-1:0]  active_mask,
  output logic                    idle
);

  localparam logic [NUM_THREADS-1:0] ONE_HOT_0 = {{(NUM_THREADS-1){1'b0}}, 1'b1};

  logic [NUM_THREADS-1:0]  active_r;
  logic [NUM_THREADS-1:0]  start_oh_s;
  logic [NUM_THREADS-1:0]  halt_oh_s;
  logic [NUM_THREADS-1:0]  awake_s;
  logic [NUM_THREADS-1:0]  elig_s;
  logic [BITS_THREADS-1:0] ptr_r;
  logic [BITS_THREADS-1:0] tid_r;
  logic [BITS_THREADS-1:0] pick_s;
  logic                    tid_valid_r;
  logic                    found_s;
  logic                    halt_cur_s;

  // Decode start/halt requests into per-thread one-hot masks.
  always_comb begin
    start_oh_s = start_valid ? (ONE_HOT_0 << start_tid) : {NUM_THREADS{1'b0}};
    halt_oh_s  = halt_valid  ? (ONE_HOT_0 << halt_tid)  : {NUM_THREADS{1'b0}};
  end

  // Active flags: start sets, halt clears, halt wins when both hit one thread.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_r <= ONE_HOT_0;
    end else begin
      active_r <= (active_r | start_oh_s) & ~halt_oh_s;
    end
  end

`ifdef MT_SCHED_SLEEP_EN
  logic [SLEEP_W-1:0]     sleep_cnt_r [NUM_THREADS];
  logic [NUM_THREADS-1:0] sleep_ld_s;

  // A sleep request only loads a live thread and only with a non-zero count.
  always_comb begin
    sleep_ld_s = (sleep_valid && (sleep_cycles != {SLEEP_W{1'b0}}))
               ? ((ONE_HOT_0 << sleep_tid) & active_r)
               : {NUM_THREADS{1'b0}};
  end

  // Per-thread sleep counters: halt clears, a new sleep overwrites, else count down to 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        sleep_cnt_r[t] <= {SLEEP_W{1'b0}};
      end
    end else begin
      for (int t = 0; t < NUM_THREADS; t++) begin
        if (halt_oh_s[t]) begin
          sleep_cnt_r[t] <= {SLEEP_W{1'b0}};
        end else if (sleep_ld_s[t]) begin
          sleep_cnt_r[t] <= sleep_cycles;
        end else if (sleep_cnt_r[t] != {SLEEP_W{1'b0}}) begin
          sleep_cnt_r[t] <= sleep_cnt_r[t] - {{(SLEEP_W-1){1'b0}}, 1'b1};
        end else begin
          sleep_cnt_r[t] <= sleep_cnt_r[t];
        end
      end
    end
  end

  // A thread is awake once its counter has drained to zero.
  always_comb begin
    awake_s = {NUM_THREADS{1'b0}};
    for (int t = 0; t < NUM_THREADS; t++) begin
      awake_s[t] = (sleep_cnt_r[t] == {SLEEP_W{1'b0}});
    end
  end
`else
  logic unused_sleep_s;

  // Without sleep support every active thread is awake; sleep inputs are dropped.
  always_comb begin
    awake_s        = {NUM_THREADS{1'b1}};
    unused_sleep_s = ^{sleep_valid, sleep_tid, sleep_cycles};
  end
`endif

  // Eligibility.  Requests normally take effect one cycle later, except that
  // halting the thread currently on tid also drops it from this cycle's pick,
  // so a halted sole survivor is never reissued after its halt edge.
  always_comb begin
    halt_cur_s = halt_valid & tid_valid_r & (halt_tid == tid_r);
    elig_s     = active_r & awake_s & ~({NUM_THREADS{halt_cur_s}} & halt_oh_s);
  end

  mt_rr_pick #(
    .NUM_THREADS  (NUM_THREADS),
    .BITS_THREADS (BITS_THREADS)
  ) u_pick (
    .eligible (elig_s),
    .ptr      (ptr_r),
    .winner   (pick_s),
    .found    (found_s)
  );

  // Issue register: freeze on stall, hold tid and pointer when nothing is eligible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tid_r       <= {BITS_THREADS{1'b0}};
      tid_valid_r <= 1'b0;
      ptr_r       <= {BITS_THREADS{1'b1}};
    end else if (fetch_stall) begin
      tid_r       <= tid_r;
      tid_valid_r <= tid_valid_r;
      ptr_r       <= ptr_r;
    end else if (found_s) begin
      tid_r       <= pick_s;
      tid_valid_r <= 1'b1;
      ptr_r       <= pick_s;
    end else begin
      tid_r       <= tid_r;
      tid_valid_r <= 1'b0;
      ptr_r       <= ptr_r;
    end
  end

  assign tid         = tid_r;
  assign tid_valid   = tid_valid_r;
  assign active_mask = active_r;
  assign idle        = ~(|active_r);

endmodule
